image_upscale_writer: RTL

Nearest-neighbour upscaler and frame-buffer writer, the write-side counterpart of the block-average downscaler. Accepts a downscaled greyscale image as a row-major pixel stream and writes each source pixel to the SDRAM frame buffer as a SCALE×SCALE block, in destination row-major order. One source row is held in an internal line buffer, then replayed SCALE times. Sits between the downscale/filter stage and the SDRAM write-port FIFO.

---
 rtl/image_upscale_writer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/image_upscale_writer.sv
// Nearest-neighbour upscaler: buffers one source row, replays it SCALE times as SCALExSCALE blocks
// to the frame-buffer write port. Define UPSCALE_GRID_EN for the debug grid overlay.
module image_upscale_writer #(
  parameter int unsigned SRC_W     = 80,
  parameter int unsigned SRC_H     = 60,
  parameter int unsigned SCALE     = 8,
  parameter logic [22:0] BASE_ADDR = 23'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        src_valid_i,
  input  logic [7:0]  src_data_i,
  output logic        src_ready_o,
  output logic        wr_en_o,
  output logic [22:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic        wr_wait_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int unsigned YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [XW-1:0] XMax = XW'(SRC_W - 1);
  localparam logic [YW-1:0] YMax = YW'(SRC_H - 1);
  localparam logic [SW-1:0] SMax = SW'(SCALE - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

  state_e        state_q;
  logic          src_ready_q;
  logic          wr_en_q;
  logic [22:0]   wr_addr_q;
  logic [7:0]    wr_data_q;
  logic          busy_q;
  logic          done_q;
  logic [XW-1:0] load_x_q;
  logic [XW-1:0] src_x_q;
  logic [SW-1:0] sub_x_q;
  logic [SW-1:0] sub_y_q;
  logic [YW-1:0] src_row_q;

  logic [7:0]    line_buf_q [SRC_W];

  logic          load_hs;
  logic          row_end;
  logic [XW-1:0] src_x_nxt;
  logic [SW-1:0] sub_x_nxt;
  logic [SW-1:0] sub_y_nxt;
  logic [7:0]    pix_nxt;
  logic [7:0]    first_pix;

  // src_ready_q is only ever high in StLoad, so this is the load handshake.
  assign load_hs = src_valid_i & src_ready_q;

  always_ff @(posedge clk) begin
    if (load_hs) begin
      line_buf_q[load_x_q] <= src_data_i;
    end
  end

  // Position and pixel of the write that follows the one currently presented.
  always_comb begin
    row_end   = (src_x_q == XMax) && (sub_x_q == SMax);
    sub_x_nxt = sub_x_q + 1'b1;
    src_x_nxt = src_x_q;
    if (sub_x_q == SMax) begin
      sub_x_nxt = '0;
      src_x_nxt = row_end ? '0 : src_x_q + 1'b1;
    end
    sub_y_nxt = row_end ? sub_y_q + 1'b1 : sub_y_q;
    pix_nxt   = line_buf_q[src_x_nxt];
`ifdef UPSCALE_GRID_EN
    if (sub_x_nxt == '0 || sub_y_nxt == '0) begin
      pix_nxt = 8'hFF;
    end
`endif
  end

  // First pixel of a row; bypass the buffer when entry 0 is being written this very cycle.
  always_comb begin
    first_pix = (load_x_q == '0) ? src_data_i : line_buf_q[0];
`ifdef UPSCALE_GRID_EN
    first_pix = 8'hFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      src_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_x_q    <= '0;
      src_x_q     <= '0;
      sub_x_q     <= '0;
      sub_y_q     <= '0;
      src_row_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StLoad;
            src_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            wr_addr_q   <= BASE_ADDR;
            load_x_q    <= '0;
            src_x_q     <= '0;
            sub_x_q     <= '0;
            sub_y_q     <= '0;
            src_row_q   <= '0;
          end
        end
        StLoad: begin
          if (load_hs) begin
            if (load_x_q == XMax) begin
              state_q     <= StEmit;
              src_ready_q <= 1'b0;
              wr_en_q     <= 1'b1;
              wr_data_q   <= first_pix;
              load_x_q    <= '0;
              src_x_q     <= '0;
              sub_x_q     <= '0;
              sub_y_q     <= '0;
            end else begin
              load_x_q <= load_x_q + 1'b1;
            end
          end
        end
        StEmit: begin
          if (!wr_wait_i) begin
            // Destination is row-major and contiguous, so the address simply counts up.
            wr_addr_q <= wr_addr_q + 23'd1;
            wr_data_q <= pix_nxt;
            sub_x_q   <= sub_x_nxt;
            src_x_q   <= src_x_nxt;
            if (row_end && sub_y_q == SMax) begin
              wr_en_q <= 1'b0;
              sub_y_q <= '0;
              if (src_row_q == YMax) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q     <= StLoad;
                src_ready_q <= 1'b1;
                src_row_q   <= src_row_q + 1'b1;
              end
            end else begin
              sub_y_q <= sub_y_nxt;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign src_ready_o = src_ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
